// File: rtl/pad_input_debouncer.sv
// -----------------------------------------------------------------------------
// pad_input_debouncer
//
// Conditions the raw input value of a bidirectional pad cell before it reaches
// peripheral or GPIO logic. The asynchronous pad value is synchronised into
// clk_i, then a candidate level change is accepted only after it has been seen
// for N consecutive cycles. The block emits the debounced level plus
// single-cycle rise / fall pulses on every accepted change and a glitch pulse
// whenever a candidate change collapses before reaching N.
//
// Ports
//   clk_i              clock
//   rst_ni             asynchronous reset, active low
//   pad_i              raw pad value, asynchronous to clk_i
//   enable_i           1 = filter active, 0 = hold level_o and abandon any count
//   debounce_cycles_i  stable cycles required (N); 0 behaves as 1
//   level_o            debounced level
//   rise_o             one-cycle pulse when level_o goes 0->1
//   fall_o             one-cycle pulse when level_o goes 1->0
//   glitch_o           one-cycle pulse when a candidate change is rejected
//
// Latency from a pad edge to level_o / pulse is SYNC_STAGES + N cycles, plus
// up to one cycle of uncertainty from sampling the asynchronous input.
// -----------------------------------------------------------------------------
module pad_input_debouncer #(
  parameter int unsigned SYNC_STAGES = 2,     // synchroniser depth, >= 2
  parameter int unsigned CNT_W       = 16,    // counter / threshold width
  parameter logic        RESET_VAL   = 1'b0   // reset value of sync chain and level_o
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pad_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] debounce_cycles_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             glitch_o
);

  typedef enum logic {
    ST_STABLE,  // level_o matches the synchronised input, or no count running
    ST_CHECK    // candidate change seen, counting consecutive mismatching cycles
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser: runs whenever out of reset, regardless of enable_i.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_val;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours, which is what
  // makes the shift chain below a chain and not a single wire.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Threshold: sampled live every cycle. A zero threshold behaves as one.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] neff;
  assign neff = (debounce_cycles_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1}
                                          : debounce_cycles_i;

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             level_q,  level_d;
  logic             rise_q,   rise_d;
  logic             fall_q,   fall_d;
  logic             glitch_q, glitch_d;

  logic             mismatch;
  logic [CNT_W:0]   cnt_inc;   // one bit wider so the compare never wraps
  logic             reached;

  assign mismatch = (sync_val != level_q);
  // In ST_STABLE the counter is always zero, so cnt_inc is 1 there and the same
  // compare covers the N == 1 "commit on the first mismatching edge" case.
  assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  // Using >= rather than == lets a threshold lowered below the running count
  // commit on the very next edge.
  assign reached  = (cnt_inc >= {1'b0, neff});

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch instead of combinational logic.
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = 1'b0;

    if (!enable_i) begin
      // Disabled: drop any pending change silently, level_o holds.
      state_d = ST_STABLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_STABLE: begin
          if (mismatch) begin
            if (reached) begin
              level_d = sync_val;
              rise_d  = sync_val;
              fall_d  = ~sync_val;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_inc[CNT_W-1:0];
              state_d = ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (!mismatch) begin
            // Input went back before the threshold: reject the candidate.
            glitch_d = 1'b1;
            cnt_d    = '0;
            state_d  = ST_STABLE;
          end else if (reached) begin
            level_d = sync_val;
            rise_d  = sync_val;
            fall_d  = ~sync_val;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end

        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      level_q  <= RESET_VAL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign glitch_o = glitch_q;

endmodule

// File: tb/tb_pad_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_pad_input_debouncer
//
// Directed bench for pad_input_debouncer (SYNC_STAGES=2, CNT_W=16,
// RESET_VAL=0). A behavioural model tracks how many consecutive enabled cycles
// the synchronised pad has disagreed with the debounced level and derives the
// expected outputs from that run length; a compare process checks the DUT
// against it every cycle. Directed scenarios add hand-computed literal
// expectations (latencies, pulse counts, reset values).
// -----------------------------------------------------------------------------
module tb_pad_input_debouncer;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             pad_i = 1'b1;
  logic             enable_i = 1'b1;
  logic [CNT_W-1:0] debounce_cycles_i = 16'd4;
  logic             level_o;
  logic             rise_o;
  logic             fall_o;
  logic             glitch_o;

  int total = 0;
  int bad   = 0;

  pad_input_debouncer #(
    .SYNC_STAGES (SYNC_STAGES),
    .CNT_W       (CNT_W),
    .RESET_VAL   (1'b0)
  ) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .pad_i             (pad_i),
    .enable_i          (enable_i),
    .debounce_cycles_i (debounce_cycles_i),
    .level_o           (level_o),
    .rise_o            (rise_o),
    .fall_o            (fall_o),
    .glitch_o          (glitch_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the pad is seen SYNC_STAGES edges late; a change is
  // accepted once it has persisted for Neff consecutive enabled edges.
  // ---------------------------------------------------------------------------
  logic m_hist [SYNC_STAGES] = '{default: 1'b0};
  logic m_level  = 1'b0;
  logic m_rise   = 1'b0;
  logic m_fall   = 1'b0;
  logic m_glitch = 1'b0;
  int   m_run    = 0;

  always @(posedge clk_i or negedge rst_ni) begin
    int  neff;
    logic seen;
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = 1'b0;
      m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
      m_run   = 0;
    end else begin
      seen = m_hist[SYNC_STAGES-1];
      neff = (debounce_cycles_i == 0) ? 1 : int'(debounce_cycles_i);
      m_rise = 1'b0; m_fall = 1'b0; m_glitch = 1'b0;
      if (!enable_i) begin
        m_run = 0;
      end else if (seen != m_level) begin
        m_run++;
        if (m_run >= neff) begin
          m_level = seen;
          m_rise  = seen;
          m_fall  = ~seen;
          m_run   = 0;
        end
      end else begin
        if (m_run > 0) m_glitch = 1'b1;
        m_run = 0;
      end
      for (int i = SYNC_STAGES-1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = pad_i;
    end
  end

  // Per-cycle comparison, one time unit after the active edge.
  always @(posedge clk_i) begin
    #1;
    check("cycle {level,rise,fall,glitch}",
          int'({level_o, rise_o, fall_o, glitch_o}),
          int'({m_level, m_rise, m_fall, m_glitch}));
  end

  // Waits up to limit edges for rise_o (which=0) or fall_o (which=1); returns
  // the edge index where it was seen, or -1 if it never appeared.
  task automatic wait_pulse(input int which, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk_i);
      #1;
      if ((which == 0 && rise_o) || (which == 1 && fall_o)) begin
        n = i;
        return;
      end
    end
  endtask

  // Toggles the pad every 3 cycles (8 toggles) and records outputs per cycle.
  task automatic run_toggle(output logic [119:0] trace, output int rises,
                            output int falls, output int first_rise,
                            output int alt_err);
    int last;
    rises = 0; falls = 0; first_rise = -1; alt_err = 0; last = 1;
    trace = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (i % 3 == 0 && i < 24) pad_i = ~pad_i;
      @(posedge clk_i);
      #1;
      trace[i*3 +: 3] = {level_o, rise_o, fall_o};
      if (rise_o) begin
        rises++;
        if (first_rise < 0) first_rise = i;
        if (last != 1) alt_err++;
        last = 0;
      end
      if (fall_o) begin
        falls++;
        if (last != 0) alt_err++;
        last = 1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, g, r, f;
    logic [119:0] tr0, tr1;
    int r0, f0, fr0, a0, r1, f1, fr1, a1;

    // 1: reset with pad high -> level 0, then rise at SYNC_STAGES+N = 6
    repeat (3) @(posedge clk_i);
    #1;
    check("reset level", int'(level_o), 0);
    check("reset pulses", int'({rise_o, fall_o, glitch_o}), 0);
    @(negedge clk_i); rst_ni = 1'b1;
    wait_pulse(0, 20, n);
    check("rise after reset latency", n, 6);
    check("level after reset rise", int'(level_o), 1);

    // 2: N=4, fall then rise, both exactly 6 cycles after the pad edge
    @(negedge clk_i); pad_i = 1'b0;
    wait_pulse(1, 20, n);
    check("fall latency N=4", n, 6);
    @(negedge clk_i); pad_i = 1'b1;
    wait_pulse(0, 20, n);
    check("rise latency N=4", n, 6);
    @(posedge clk_i); #1;
    check("rise lasts one cycle", int'(rise_o), 0);

    // 3: N=4, 3-cycle high pulse from level 0 -> one glitch, no rise
    @(negedge clk_i); pad_i = 1'b0;
    wait_pulse(1, 20, n);
    g = 0; r = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      if (i == 0) pad_i = 1'b1;
      if (i == 3) pad_i = 1'b0;
      @(posedge clk_i); #1;
      g += int'(glitch_o);
      r += int'(rise_o);
    end
    check("short pulse glitch count", g, 1);
    check("short pulse rise count", r, 0);
    check("short pulse level", int'(level_o), 0);

    // 4: N=0 vs N=1 under a 3-cycle toggle pattern
    @(negedge clk_i); debounce_cycles_i = 16'd0;
    run_toggle(tr0, r0, f0, fr0, a0);
    @(negedge clk_i); debounce_cycles_i = 16'd1;
    run_toggle(tr1, r1, f1, fr1, a1);
    check("N=0 vs N=1 traces equal", int'(tr0 == tr1), 1);
    check("N=0 rises", r0, 4);
    check("N=0 falls", f0, 4);
    check("N=0 first change after 3 cycles", fr0, 2);
    check("N=1 first change after 3 cycles", fr1, 2);
    check("rise/fall alternate", a0 + a1, 0);

    // 5: N=10, disable at count 5, re-enable -> rise 10 cycles later
    @(negedge clk_i); debounce_cycles_i = 16'd10; pad_i = 1'b1;
    repeat (7) @(posedge clk_i);
    @(negedge clk_i); enable_i = 1'b0;
    r = 0;
    repeat (12) begin
      @(posedge clk_i); #1;
      r += int'(rise_o) + int'(fall_o) + int'(glitch_o);
    end
    check("disabled pulses", r, 0);
    check("disabled level holds", int'(level_o), 0);
    @(negedge clk_i); enable_i = 1'b1;
    wait_pulse(0, 30, n);
    check("rise after re-enable", n, 10);

    // 6: N=8 counting to 5, threshold lowered to 3 -> commit next edge
    @(negedge clk_i); debounce_cycles_i = 16'd1; pad_i = 1'b0;
    wait_pulse(1, 20, n);
    check("fall latency N=1", n, 3);
    @(negedge clk_i); debounce_cycles_i = 16'd8; pad_i = 1'b1;
    repeat (7) @(posedge clk_i);
    @(negedge clk_i); debounce_cycles_i = 16'd3;
    wait_pulse(0, 10, n);
    check("commit after threshold lowered", n, 1);

    // then async reset while a fall is pending
    @(negedge clk_i); debounce_cycles_i = 16'd8; pad_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #3;
    check("level before mid-check reset", int'(level_o), 1);
    rst_ni = 1'b0;
    #1;
    check("mid-check reset level", int'(level_o), 0);
    check("mid-check reset pulses", int'({rise_o, fall_o, glitch_o}), 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    r = 0; f = 0;
    repeat (15) begin
      @(posedge clk_i); #1;
      r += int'(rise_o) + int'(glitch_o);
      f += int'(fall_o);
    end
    check("no pulses after reset release", r + f, 0);
    check("level after reset release", int'(level_o), 0);

    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
